// File: rtl/vend_pkg.sv
// vend_pkg: shared types, widths and helpers for the vending controller
package vend_pkg;
    localparam int NUM_PROD = 10;
    localparam int ID_W = 4;
    localparam int CREDIT_W = 8;
    localparam int STOCK_W = 4;

    typedef enum logic [2:0] {IDLE, CHECK, PAY, DISPENSE, CHANGE} state_t;

    function automatic logic valid_id(input logic [ID_W-1:0] id);
        return id != '0 && id <= ID_W'(NUM_PROD);
    endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: front-panel, restock and actuator signals of the vending controller
interface vend_if;
    import vend_pkg::*;
    logic sel_valid;
    logic [ID_W-1:0] sel_no;
    logic coin_valid;
    logic [CREDIT_W-1:0] coin_val;
    logic cancel;
    logic restock_valid;
    logic [ID_W-1:0] restock_no;
    logic [STOCK_W-1:0] restock_qty;
    logic busy;
    logic in_stock;
    logic reject;
    logic coin_return;
    logic dispense_valid;
    logic [ID_W-1:0] dispense_no;
    logic change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W*NUM_PROD-1:0] stock_flat;

    modport master (
        output sel_valid, sel_no, coin_valid, coin_val, cancel, restock_valid, restock_no, restock_qty,
        input busy, in_stock, reject, coin_return, dispense_valid, dispense_no, change_valid, change_amt,
        credit, stock_flat
    );
    modport slave (
        input sel_valid, sel_no, coin_valid, coin_val, cancel, restock_valid, restock_no, restock_qty,
        output busy, in_stock, reject, coin_return, dispense_valid, dispense_no, change_valid, change_amt,
        credit, stock_flat
    );
endinterface

// File: rtl/vend_stock_bank.sv
// vend_stock_bank: per-product stock counters with dispense decrement and saturating restock
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter logic [STOCK_W-1:0] INIT_STOCK = 4'd5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dec_valid,
    input  logic [ID_W-1:0]             dec_no,
    input  logic                        rs_valid,
    input  logic [ID_W-1:0]             rs_no,
    input  logic [STOCK_W-1:0]          rs_qty,
    input  logic [ID_W-1:0]             rd_no,
    output logic [STOCK_W-1:0]          rd_stock,
    output logic [STOCK_W*NUM_PROD-1:0] stock_flat
);
    logic [STOCK_W-1:0] stock [NUM_PROD];

    for (genvar i = 0; i < NUM_PROD; i++) begin : g_ent
        logic [STOCK_W-1:0] q;
        logic dec, add;
        logic [STOCK_W:0] sum;
        // decrement and restock merge into one sum so a same-cycle pair never loses either update
        assign dec = dec_valid && dec_no == ID_W'(i + 1) && q != '0;
        assign add = rs_valid && rs_no == ID_W'(i + 1);
        assign sum = {1'b0, q} + (add ? {1'b0, rs_qty} : '0) - {{STOCK_W{1'b0}}, dec};
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) q <= INIT_STOCK;
            else q <= sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
        assign stock[i] = q;
        assign stock_flat[STOCK_W*i +: STOCK_W] = q;
    end

    assign rd_stock = stock[rd_no - ID_W'(1)];
endmodule

// File: rtl/vend_controller.sv
// vend_controller: select, stock check, coin credit, dispense and change sequencing
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [CREDIT_W-1:0] PRICE = 8'd25,
    parameter logic [STOCK_W-1:0] INIT_STOCK = 4'd5,
    parameter int TIMEOUT = 1000
) (
    input logic   clk,
    input logic   rst_n,
    vend_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    state_t state;
    logic [ID_W-1:0] id;
    logic [CREDIT_W-1:0] credit, pay_credit, left;
    logic [CREDIT_W:0] coin_sum;
    logic [TMR_W-1:0] tmr;
    logic [STOCK_W-1:0] cur_stock;

    assign coin_sum = {1'b0, credit} + {1'b0, bus.coin_val};
    assign pay_credit = !bus.coin_valid ? credit : coin_sum[CREDIT_W] ? '1 : coin_sum[CREDIT_W-1:0];
    assign left = credit - PRICE;
    assign bus.busy = state != IDLE;
    assign bus.credit = credit;

    vend_stock_bank #(.INIT_STOCK(INIT_STOCK)) u_stock (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_valid  (state == DISPENSE),
        .dec_no     (id),
        .rs_valid   (bus.restock_valid),
        .rs_no      (bus.restock_no),
        .rs_qty     (bus.restock_qty),
        .rd_no      (id),
        .rd_stock   (cur_stock),
        .stock_flat (bus.stock_flat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            id <= '0;
            credit <= '0;
            tmr <= '0;
            bus.in_stock <= 1'b0;
            bus.reject <= 1'b0;
            bus.coin_return <= 1'b0;
            bus.dispense_valid <= 1'b0;
            bus.dispense_no <= '0;
            bus.change_valid <= 1'b0;
            bus.change_amt <= '0;
        end else begin
            bus.reject <= 1'b0;
            bus.coin_return <= bus.coin_valid && state != PAY;
            bus.dispense_valid <= 1'b0;
            bus.dispense_no <= '0;
            bus.change_valid <= 1'b0;
            bus.change_amt <= '0;
            case (state)
                IDLE:
                    if (bus.sel_valid) begin
                        if (valid_id(bus.sel_no)) begin
                            id <= bus.sel_no;
                            state <= CHECK;
                        end else bus.reject <= 1'b1;
                    end
                CHECK: begin
                    bus.in_stock <= cur_stock != '0;
                    bus.reject <= cur_stock == '0;
                    state <= cur_stock != '0 ? PAY : IDLE;
                    tmr <= '0;
                end
                PAY: begin
                    // a coin arriving with cancel is credited first, so the refund includes it
                    credit <= pay_credit;
                    tmr <= bus.coin_valid ? '0 : tmr + 1'b1;
                    if (credit >= PRICE) begin
                        state <= DISPENSE;
                        bus.dispense_valid <= 1'b1;
                        bus.dispense_no <= id;
                    end else if (bus.cancel || tmr == TMR_MAX) begin
                        state <= CHANGE;
                        bus.change_valid <= pay_credit != '0;
                        bus.change_amt <= pay_credit;
                    end
                end
                DISPENSE: begin
                    credit <= left;
                    bus.change_valid <= left != '0;
                    bus.change_amt <= left;
                    state <= CHANGE;
                end
                CHANGE: begin
                    credit <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
